// File: rtl/guess_ctrl_pkg.sv
// Shared constants for the bit-match guessing game controller.
// State encodings are fixed so external checkers can decode the FSM.
package guess_ctrl_pkg;

   localparam int          GUESS_W  = 6;
   localparam logic [2:0]  ST_IDLE  = 3'd0;
   localparam logic [2:0]  ST_PLAY  = 3'd1;
   localparam logic [2:0]  ST_CHECK = 3'd2;
   localparam logic [2:0]  ST_WIN   = 3'd3;
   localparam logic [2:0]  ST_LOSE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      PLAY  = ST_PLAY,
      CHECK = ST_CHECK,
      WIN   = ST_WIN,
      LOSE  = ST_LOSE
   } state_t;

endpackage

// File: rtl/guess_ctrl_match_count.sv
// Combinational scorer: counts bit positions where guess equals secret.
module match_count
   import guess_ctrl_pkg::*;
(
   input  logic [GUESS_W-1:0] secret,
   input  logic [GUESS_W-1:0] guess,
   output logic [2:0]         cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < GUESS_W; i++) begin
         cnt = cnt + {2'b00, ~(secret[i] ^ guess[i])};
      end
   end

endmodule

// File: rtl/guess_ctrl.sv
// Guessing-game controller: holds the secret, accepts guesses, scores them
// one cycle later and tracks attempts until a win or loss.
module guess_ctrl
   import guess_ctrl_pkg::*;
#(
   parameter int MAX_TRIES = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ans_load,
   input  logic [GUESS_W-1:0] ans_in,
   input  logic               guess_valid,
   input  logic [GUESS_W-1:0] guess_in,
   output logic               guess_ready,
   output logic               result_valid,
   output logic [2:0]         match_cnt,
   output logic [3:0]         attempts,
   output logic               win,
   output logic               lose,
   output logic               busy
);

   localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES);

   // Handshake: a guess transfers on a rising edge where guess_valid and
   // guess_ready are both high; ready is only offered in PLAY, never with ans_load.
   state_t             state, state_next;
   logic [GUESS_W-1:0] secret, guess_reg;
   logic [2:0]         score;
   logic               take_guess, do_score, last_try;

   match_count u_match_count (
      .secret (secret),
      .guess  (guess_reg),
      .cnt    (score)
   );

   assign guess_ready = (state == PLAY) && !ans_load;
   assign take_guess  = guess_ready && guess_valid;
   assign do_score    = (state == CHECK) && !ans_load;
   assign last_try    = (attempts + 4'd1) == LAST_TRY;
   assign win         = (state == WIN);
   assign lose        = (state == LOSE);
   assign busy        = (state == PLAY) || (state == CHECK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (ans_load) begin
         state_next = PLAY;
      end else begin
         case (state)
            PLAY:    if (guess_valid) state_next = CHECK;
            CHECK: begin
               // A full match on the final try is a win, not a loss.
               if (score == 3'd6)  state_next = WIN;
               else if (last_try)  state_next = LOSE;
               else                state_next = PLAY;
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         secret       <= '0;
         guess_reg    <= '0;
         match_cnt    <= '0;
         attempts     <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (ans_load) begin
            secret    <= ans_in;
            match_cnt <= '0;
            attempts  <= '0;
         end else if (take_guess) begin
            guess_reg <= guess_in;
         end else if (do_score) begin
            match_cnt    <= score;
            attempts     <= attempts + 4'd1;
            result_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_guess_ctrl.sv
// Bench for guess_ctrl: directed game scenarios followed by random play,
// all checked against a round-level reference model of the game.
module tb_guess_ctrl;

   localparam int MAX_TRIES = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ans_load = 1'b0;
   logic [5:0] ans_in = '0;
   logic       guess_valid = 1'b0;
   logic [5:0] guess_in = '0;
   logic       guess_ready, result_valid, win, lose, busy;
   logic [2:0] match_cnt;
   logic [3:0] attempts;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: game round as the player sees it
   logic [5:0] m_secret, m_guess;
   bit         m_active, m_pending, m_win, m_lose, m_rv;
   int         m_attempts, m_match;

   guess_ctrl #(.MAX_TRIES(MAX_TRIES)) dut (
      .clk          (clk),
      .reset        (reset),
      .ans_load     (ans_load),
      .ans_in       (ans_in),
      .guess_valid  (guess_valid),
      .guess_in     (guess_in),
      .guess_ready  (guess_ready),
      .result_valid (result_valid),
      .match_cnt    (match_cnt),
      .attempts     (attempts),
      .win          (win),
      .lose         (lose),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic int bit_matches(logic [5:0] s, logic [5:0] g);
      int c = 0;
      for (int i = 0; i < 6; i++) if (s[i] == g[i]) c++;
      return c;
   endfunction

   task automatic check(string tag, int obs, int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_secret = '0; m_guess = '0;
      m_active = 0; m_pending = 0; m_win = 0; m_lose = 0; m_rv = 0;
      m_attempts = 0; m_match = 0;
   endtask

   function automatic bit model_ready(bit al);
      return m_active && !m_pending && !m_win && !m_lose && !al;
   endfunction

   task automatic model_edge(bit al, logic [5:0] ai, bit gv, logic [5:0] gi);
      m_rv = 0;
      if (al) begin
         m_secret = ai; m_attempts = 0; m_match = 0;
         m_win = 0; m_lose = 0; m_active = 1; m_pending = 0;
      end else if (m_pending) begin
         m_match = bit_matches(m_secret, m_guess);
         m_attempts++;
         m_rv = 1;
         m_pending = 0;
         if (m_match == 6) m_win = 1;
         else if (m_attempts == MAX_TRIES) m_lose = 1;
      end else if (model_ready(1'b0) && gv) begin
         m_guess = gi;
         m_pending = 1;
      end
   endtask

   task automatic check_outputs(string tag);
      check({tag, ".result_valid"}, int'(result_valid), int'(m_rv));
      check({tag, ".match_cnt"},    int'(match_cnt),    m_match);
      check({tag, ".attempts"},     int'(attempts),     m_attempts);
      check({tag, ".win"},          int'(win),          int'(m_win));
      check({tag, ".lose"},         int'(lose),         int'(m_lose));
      check({tag, ".busy"},         int'(busy),         int'(m_active && !m_win && !m_lose));
   endtask

   // One clock of stimulus: ready is checked before the edge, the rest after it.
   task automatic step(string tag, bit al, logic [5:0] ai, bit gv, logic [5:0] gi);
      @(negedge clk);
      ans_load = al; ans_in = ai; guess_valid = gv; guess_in = gi;
      #1 check({tag, ".guess_ready"}, int'(guess_ready), int'(model_ready(al)));
      @(posedge clk);
      #1 model_edge(al, ai, gv, gi);
      check_outputs(tag);
   endtask

   task automatic do_reset(string tag);
      @(negedge clk);
      reset = 1'b1;
      #1 model_reset();
      check({tag, ".guess_ready"}, int'(guess_ready), 0);
      check_outputs(tag);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit         al, gv;
      logic [5:0] ai, gi;
      model_reset();

      // reset then idle: guesses ignored
      repeat (2) @(posedge clk);
      #1 check_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step("idle", 0, 6'h00, 1, 6'h3F);

      // load and partial score
      step("p_load", 1, 6'b101010, 0, 6'h00);
      step("p_guess", 0, 6'h00, 1, 6'b101011);
      step("p_score", 0, 6'h00, 0, 6'h00);
      check("p_score.const_match", int'(match_cnt), 5);
      check("p_score.const_att", int'(attempts), 1);

      // win, then further guesses are ignored
      step("w_load", 1, 6'b110011, 0, 6'h00);
      step("w_guess", 0, 6'h00, 1, 6'b110011);
      step("w_score", 0, 6'h00, 1, 6'b110011);
      check("w_score.const_win", int'(win), 1);
      for (int i = 0; i < 3; i++) step("w_after", 0, 6'h00, 1, 6'h15);
      check("w_after.const_att", int'(attempts), 1);

      // lose after MAX_TRIES all-wrong guesses
      step("l_load", 1, 6'b000000, 0, 6'h00);
      for (int i = 0; i < MAX_TRIES; i++) begin
         step("l_guess", 0, 6'h00, 1, 6'b111111);
         step("l_score", 0, 6'h00, 0, 6'h00);
      end
      check("l_end.const_lose", int'(lose), 1);
      step("l_extra", 0, 6'h00, 1, 6'b000000);

      // win on the final try
      step("f_load", 1, 6'b011100, 0, 6'h00);
      for (int i = 0; i < MAX_TRIES - 1; i++) begin
         step("f_miss", 0, 6'h00, 1, 6'b100011);
         step("f_miss_s", 0, 6'h00, 0, 6'h00);
      end
      step("f_hit", 0, 6'h00, 1, 6'b011100);
      step("f_hit_s", 0, 6'h00, 0, 6'h00);
      check("f_hit.const_win", int'(win), 1);
      check("f_hit.const_lose", int'(lose), 0);

      // collisions: load with guess in PLAY, load during CHECK
      step("c_load", 1, 6'h2A, 0, 6'h00);
      step("c_both", 1, 6'h15, 1, 6'h15);
      step("c_guess", 0, 6'h00, 1, 6'h15);
      step("c_ldchk", 1, 6'h0F, 0, 6'h00);
      step("c_after", 0, 6'h00, 0, 6'h00);

      // reset asserted mid-CHECK
      step("r_guess", 0, 6'h00, 1, 6'h0F);
      do_reset("r_chk");
      step("r_idle", 0, 6'h00, 1, 6'h0F);

      // random play
      for (int i = 0; i < 400; i++) begin
         al = ($urandom_range(0, 11) == 0);
         ai = 6'($urandom);
         gv = ($urandom_range(0, 9) < 7);
         gi = ($urandom_range(0, 3) == 0) ? m_secret : 6'($urandom);
         step("rand", al, ai, gv, gi);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
